// File: rtl/alu_exec.sv
// ----------------------------------------------------------------------------
// alu_exec -- execute-stage ALU for a 32-bit RV32I/M core.
//
// Single-cycle operations (ADD..SLTU, plus the unused codes 13-15) register
// their result on the start edge. MUL, DIVU and REMU are sequential units. They
// latch their operands on the start edge and then run one iteration per clock
// for ITER clocks, holding busy high so the control unit can stall the pipe.
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   rst     in   synchronous active-high reset
//   start   in   sample alu_op/op_a/op_b on this edge (ignored while busy)
//   alu_op  in   [3:0] operation select
//   op_a    in   [XLEN-1:0] first operand, Reg[rs1]
//   op_b    in   [XLEN-1:0] second operand, from the ALU source mux
//   result  out  [XLEN-1:0] registered result, held between done pulses
//   zero    out  registered flag, 1 when result == 0
//   busy    out  1 while an iterative operation is in progress
//   done    out  one-cycle pulse; result/zero are valid
// ----------------------------------------------------------------------------
module alu_exec #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy,
    output logic            done
);

    localparam int CNT_W   = $clog2(ITER);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;      // multiplicand (MUL) / dividend shifting into quotient (DIV)
    logic [XLEN-1:0]   b_q, b_d;      // multiplier (MUL) / divisor (DIV)
    logic [XLEN:0]     rem_q, rem_d;  // product accumulator (MUL) / partial remainder (DIV)
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               is_iter;

    assign shamt   = op_b[SHAMT_W-1:0];
    assign is_iter = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of the sequential units
    // ------------------------------------------------------------------
    logic [XLEN+1:0] rem_sh;   // remainder shifted left with the next dividend bit
    logic [XLEN+1:0] diff;     // trial subtraction; MSB is the borrow
    logic            q_bit;
    logic [XLEN-1:0] mul_acc;
    logic [XLEN-1:0] a_nx;
    logic [XLEN-1:0] b_nx;
    logic [XLEN:0]   rem_nx;
    logic [XLEN-1:0] fin_res;

    assign rem_sh  = {rem_q, a_q[XLEN-1]};
    assign diff    = rem_sh - {2'b00, b_q};
    assign q_bit   = ~diff[XLEN+1];
    assign mul_acc = rem_q[XLEN-1:0] + (b_q[0] ? a_q : '0);

    always_comb begin
        a_nx    = a_q;
        b_nx    = b_q;
        rem_nx  = rem_q;
        fin_res = '0;
        if (op_q == OP_MUL) begin
            a_nx    = a_q << 1;
            b_nx    = b_q >> 1;
            rem_nx  = {1'b0, mul_acc};
            fin_res = mul_acc;
        end else begin
            // Restoring division. A zero divisor never borrows, so the
            // quotient fills with ones and the remainder collects the dividend.
            a_nx    = {a_q[XLEN-2:0], q_bit};
            rem_nx  = q_bit ? diff[XLEN:0] : rem_sh[XLEN:0];
            fin_res = (op_q == OP_DIVU) ? a_nx : rem_nx[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    // NOTE: the operand/accumulator registers carry no reset; they are only
    // read in RUN, and every entry into RUN loads them first.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        rem_q <= rem_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state and register-update logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_iter) begin
                        op_d    = alu_op;
                        a_d     = op_a;
                        b_d     = op_b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                a_d   = a_nx;
                b_d   = b_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    result_d = fin_res;
                    zero_d   = (fin_res == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (state_q == RUN);
        result = result_q;
        zero   = zero_q;
        done   = done_q;
    end

endmodule
